// File: rtl/bar_pkg.sv
// Shared types for the `bar` valid/ready stream.
//   DATA_W      : stream word width
//   bar_data_t  : one stream word
//   bar_state_t : output-stage state (ST_EMPTY = nothing held, ST_FULL = word on y)
package bar_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] bar_data_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } bar_state_t;

endpackage

// File: rtl/bar_if.sv
// `bar` valid/ready stream interface.
//   data  : word presented by the producer
//   valid : producer holds a word
//   ready : consumer accepts at the edge where valid && ready
// Modports: out = producer side, in = consumer side.
interface bar;
    import bar_pkg::*;

    bar_data_t data;
    logic      valid;
    logic      ready;

    modport out (output data, output valid, input ready);
    modport in  (input data, input valid, output ready);

endinterface

// File: rtl/bar_fifo.sv
// Synchronous FIFO of bar_data_t words.
//   clk, rst  : clock, synchronous active-high reset
//   push      : enqueue push_data (ignored while full)
//   pop       : dequeue head (ignored while empty)
//   head      : word at the read pointer
//   full      : occupancy == DEPTH
//   empty     : occupancy == 0
// Pointers are log2(DEPTH) bits and wrap naturally; a separate occupancy
// counter distinguishes full from empty.
module bar_fifo
    import bar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  bar_data_t push_data,
    input  logic      pop,
    output bar_data_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bar_data_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (occ == (AW+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once occ clears.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/bar_source.sv
// Transmitter end of a `bar` stream: local write port -> FIFO -> output register.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : push request for wr_data
//   wr_data  : word to enqueue
//   wr_full  : FIFO holds DEPTH entries; a push now is dropped
//   overflow : sticky, set by any dropped push
//   y        : bar.out stream port (data/valid out, ready in)
//   sent_cnt : completed transfers, wrapping
//   idle     : FIFO empty and nothing held on y
module bar_source
    import bar_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  bar_data_t        wr_data,
    output logic             wr_full,
    output logic             overflow,
    bar.out                  y,
    output logic [CNT_W-1:0] sent_cnt,
    output logic             idle
);

    bar_state_t state;
    bar_state_t state_nxt;
    bar_data_t  data_q;
    bar_data_t  head;
    logic       fifo_pop;
    logic       fifo_empty;
    logic       xfer;

    // wr_full comes straight from registered occupancy, so a push while full is
    // dropped even when the output stage pops in the same cycle.
    bar_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (wr_full),
        .empty     (fifo_empty)
    );

    assign y.valid = (state == ST_FULL);
    assign y.data  = data_q;
    assign xfer    = y.valid && y.ready;
    assign idle    = fifo_empty && !y.valid;

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Hold data/valid until the consumer takes the word.
                if (y.ready) begin
                    if (!fifo_empty) fifo_pop  = 1'b1;
                    else             state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            data_q   <= '0;
            overflow <= 1'b0;
            sent_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop)          data_q   <= head;
            if (wr_en && wr_full)  overflow <= 1'b1;
            if (xfer)              sent_cnt <= sent_cnt + 1'b1;
        end
    end

endmodule
